// File: rtl/ex_stage_md.sv
// ex_stage_md: MIPS execute stage with ID/EX register, single-cycle ALU and
// an iterative radix-2 multiply/divide unit.
//   clk, rst_n       : clock, synchronous active-low reset
//   id_*             : instruction presented by ID (held by ID while ex_busy)
//   ex_flush         : squash incoming instruction, abort in-flight mul/div
//   ex_busy          : stall request to ID while mul/div iterates
//   ex_*             : registered controls/data and ALU result to MEM
module ex_stage_md #(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5,
   parameter int TAG_W   = 8,
   parameter int SH_W    = $clog2(DATA_W)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               id_valid,
   input  logic [DATA_W-1:0]  id_imm,
   input  logic [DATA_W-1:0]  id_inA,
   input  logic [DATA_W-1:0]  id_inB,
   input  logic               id_wreg,
   input  logic               id_m2reg,
   input  logic               id_wmem,
   input  logic [3:0]         id_aluc,
   input  logic               id_aluimm,
   input  logic               id_shift,
   input  logic [1:0]         id_md,
   input  logic [RADDR_W-1:0] id_destR,
   input  logic [TAG_W-1:0]   id_tag,
   input  logic               ex_flush,
   output logic               ex_busy,
   output logic               ex_valid,
   output logic               ex_wreg,
   output logic               ex_m2reg,
   output logic               ex_wmem,
   output logic [DATA_W-1:0]  ex_aluR,
   output logic [DATA_W-1:0]  ex_inB,
   output logic [RADDR_W-1:0] ex_destR,
   output logic               ex_zero,
   output logic [TAG_W-1:0]   ex_tag
);

   typedef struct packed {
      logic               valid;
      logic               wreg;
      logic               m2reg;
      logic               wmem;
      logic [1:0]         md;
      logic [3:0]         aluc;
      logic               aluimm;
      logic               shift;
      logic [DATA_W-1:0]  imm;
      logic [DATA_W-1:0]  ina;
      logic [DATA_W-1:0]  inb;
      logic [RADDR_W-1:0] destr;
      logic [TAG_W-1:0]   tag;
   } idex_t;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   idex_t             r_q, r_d;
   state_t            st_q, st_d;
   logic [SH_W-1:0]   cnt_q, cnt_d;
   // mul: acc = partial product, x = shifted multiplicand, y = multiplier
   // div: acc = partial remainder, x = dividend/quotient, y = divisor
   logic [DATA_W-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d;

   logic              cap_ok, load, cap_md;
   logic [DATA_W:0]   rsh, rdiff;
   logic [DATA_W-1:0] a_in, b_in, alu_r, md_r;

   // A operand: shift amount from imm[10:6] or register operand
   function automatic logic [DATA_W-1:0] sel_a(input logic sh,
                                               input logic [DATA_W-1:0] imm,
                                               input logic [DATA_W-1:0] ina);
      return sh ? ((imm >> 6) & DATA_W'(31)) : ina;
   endfunction

   assign ex_busy = (st_q == S_RUN);
   assign cap_ok  = id_valid & ~ex_flush;
   // a flush during RUN forces a bubble in even though ID is stalled
   assign load    = ~ex_busy | ex_flush;
   assign cap_md  = cap_ok & (id_md != 2'b00);

   always_comb begin
      r_d = r_q;
      if (load) begin
         r_d.valid  = cap_ok;
         r_d.wreg   = cap_ok & id_wreg;
         r_d.m2reg  = cap_ok & id_m2reg;
         r_d.wmem   = cap_ok & id_wmem;
         r_d.md     = cap_ok ? id_md : 2'b00;
         r_d.aluc   = id_aluc;
         r_d.aluimm = id_aluimm;
         r_d.shift  = id_shift;
         r_d.imm    = id_imm;
         r_d.ina    = id_inA;
         r_d.inb    = id_inB;
         r_d.destr  = id_destR;
         r_d.tag    = id_tag;
      end
   end

   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      acc_d = acc_q;
      x_d   = x_q;
      y_d   = y_q;
      // restoring-divide trial subtract; bit DATA_W of rdiff is the borrow
      rsh   = {acc_q, x_q[DATA_W-1]};
      rdiff = rsh - {1'b0, y_q};
      case (st_q)
         S_RUN: begin
            if (ex_flush) begin
               st_d = S_IDLE;
            end else begin
               if (r_q.md == 2'b01) begin
                  if (y_q[0]) acc_d = acc_q + x_q;
                  x_d = x_q << 1;
                  y_d = y_q >> 1;
               end else if (!rdiff[DATA_W]) begin
                  acc_d = rdiff[DATA_W-1:0];
                  x_d   = {x_q[DATA_W-2:0], 1'b1};
               end else begin
                  acc_d = rsh[DATA_W-1:0];
                  x_d   = {x_q[DATA_W-2:0], 1'b0};
               end
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == SH_W'(DATA_W - 1)) st_d = S_DONE;
            end
         end
         default: begin
            // IDLE and DONE both capture; operands latched from ID directly
            if (cap_md) begin
               st_d  = S_RUN;
               cnt_d = '0;
               acc_d = '0;
               x_d   = sel_a(id_shift, id_imm, id_inA);
               y_d   = id_aluimm ? id_imm : id_inB;
            end else begin
               st_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q   <= '0;
         st_q  <= S_IDLE;
         cnt_q <= '0;
         acc_q <= '0;
         x_q   <= '0;
         y_q   <= '0;
      end else begin
         r_q   <= r_d;
         st_q  <= st_d;
         cnt_q <= cnt_d;
         acc_q <= acc_d;
         x_q   <= x_d;
         y_q   <= y_d;
      end
   end

   assign a_in = sel_a(r_q.shift, r_q.imm, r_q.ina);
   assign b_in = r_q.aluimm ? r_q.imm : r_q.inb;

   always_comb begin
      alu_r = '0;
      case (r_q.aluc)
         4'd0:  alu_r = a_in + b_in;
         4'd1:  alu_r = a_in - b_in;
         4'd2:  alu_r = a_in & b_in;
         4'd3:  alu_r = a_in | b_in;
         4'd4:  alu_r = a_in ^ b_in;
         4'd5:  alu_r = ~(a_in | b_in);
         4'd6:  alu_r = DATA_W'($signed(a_in) < $signed(b_in));
         4'd7:  alu_r = DATA_W'(a_in < b_in);
         4'd8:  alu_r = b_in << a_in[SH_W-1:0];
         4'd9:  alu_r = b_in >> a_in[SH_W-1:0];
         4'd10: alu_r = $unsigned($signed(b_in) >>> a_in[SH_W-1:0]);
         4'd11: alu_r = b_in << (DATA_W / 2);
         default: alu_r = '0;
      endcase
   end

   assign md_r     = (r_q.md == 2'b10) ? x_q : acc_q;
   assign ex_aluR  = (r_q.md != 2'b00) ? md_r : alu_r;
   assign ex_zero  = (ex_aluR == '0);
   assign ex_valid = r_q.valid & ~ex_busy;
   assign ex_wreg  = r_q.wreg  & ~ex_busy;
   assign ex_m2reg = r_q.m2reg & ~ex_busy;
   assign ex_wmem  = r_q.wmem  & ~ex_busy;
   assign ex_inB   = r_q.inb;
   assign ex_destR = r_q.destr;
   assign ex_tag   = r_q.tag;

endmodule

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
Parametrised execute stage for the 5-stage MIPS pipeline. It holds the ID/EX pipeline register and a single-cycle ALU with shift-amount and immediate operand muxing. It adds three things: an iterative multi-cycle multiply/divide unit, an upstream stall output, and a flush input for squashing instructions. It sits between the ID stage and the EX/MEM register, and its outputs drive the MEM stage directly.

Parameters:
DATA_W, 32, datapath width; a power of two, at least 8
RADDR_W, 5, destination register address width
TAG_W, 8, debug tracking tag width, carried through unchanged
SH_W, $clog2(DATA_W), shift-amount width (derived)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous, active-low reset
id_valid  in  1  ID is presenting a real instruction
id_imm  in  DATA_W  sign-extended immediate
id_inA  in  DATA_W  operand A
id_inB  in  DATA_W  operand B; also the store data
id_wreg  in  1  register write enable
id_m2reg  in  1  writeback comes from memory
id_wmem  in  1  memory write enable
id_aluc  in  4  ALU opcode
id_aluimm  in  1  B operand = immediate
id_shift  in  1  A operand = shift amount
id_md  in  2  00 none, 01 MULU low half, 10 DIVU quotient, 11 DIVU remainder
id_destR  in  RADDR_W  destination register
id_tag  in  TAG_W  instruction type/number tag
ex_flush  in  1  squash the incoming instruction and abort any in-flight mul/div
ex_busy  out  1  stall: ID must hold its outputs
ex_valid, ex_wreg, ex_m2reg, ex_wmem  out  1 each  registered control
ex_aluR  out  DATA_W  result
ex_inB  out  DATA_W  registered operand B (store data)
ex_destR  out  RADDR_W  registered destination
ex_zero  out  1  ex_aluR == 0
ex_tag  out  TAG_W  registered tag

Behaviour:
- Reset (rst_n=0 at an edge): all registers cleared, FSM goes to IDLE, every output reads 0 (ex_zero reads 1), ex_busy=0.
- Capture: the ID/EX register loads on every edge where ex_busy=0.
  - If id_valid=0 or ex_flush=1, it loads a bubble: valid, wreg, m2reg, wmem and md all 0; data fields don't-care.
- Single-cycle ops (md=00): outputs are combinational from the register in the cycle after capture.
  - a_in = shift ? zero-extended imm[10:6] : inA.
  - b_in = aluimm ? imm : inB.
- ALU opcodes (others produce 0):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed), 7 SLTU
  - 8 SLL b<<a[SH_W-1:0], 9 SRL, 10 SRA
  - 11 LUI b<<(DATA_W/2)
  - Add/sub wrap modulo 2^DATA_W; no overflow trap.
- Mul/div FSM:
  - IDLE: on capture with md!=00, go to RUN, counter=0, ex_busy=1.
  - RUN: one radix-2 step per cycle (shift-add multiply, restoring divide), counter+1. After DATA_W steps go to DONE.
  - ex_busy is high for exactly DATA_W cycles after the capturing edge.
  - During RUN, ex_valid, ex_wreg, ex_m2reg and ex_wmem are forced to 0 (downstream sees bubbles).
  - DONE: ex_busy=0, ex_aluR = result, controls unmasked for one cycle. The next edge captures a new instruction and returns to IDLE, or re-enters RUN if that instruction is another mul/div.
- Results:
  - MULU gives the low DATA_W bits of the unsigned product.
  - DIVU by 0 gives quotient = all ones and remainder = dividend.
  - Operands are taken from b_in/a_in as latched at capture.
- ex_flush while busy (RUN): at that edge the FSM aborts to IDLE, the register loads a bubble and ex_busy drops the next cycle. No result is ever presented.
- ex_flush with ex_busy=0: the incoming instruction is squashed; the instruction already in EX is unaffected.
- rst_n=0 mid-RUN: same as a full reset; wins over flush.
- ex_inB always equals the registered inB; ex_tag passes through unchanged, including during RUN.

Test Plan:
- Reset: hold rst_n=0 two cycles with id_valid=1 -> all outputs 0, ex_zero=1, ex_busy=0.
- ADD with immediate: inA=5, imm=0xFFFFFFFD, aluimm=1, aluc=0, wreg=1 -> next cycle ex_aluR=2, ex_wreg=1, ex_zero=0.
- SRA by shift amount: inB=0x80000000, imm[10:6]=4, shift=1, aluc=10 -> ex_aluR=0xF8000000.
- MULU: inA=0x10001, inB=0x10001, md=01 -> ex_busy high exactly 32 cycles, ex_wreg=0 throughout, then ex_aluR=0x00020001 with ex_wreg=1 for one cycle. An ADD presented behind it is captured only at the DONE edge.
- DIVU: 100/7 md=10 -> 14; md=11 -> 2. DIVU 9/0 -> quotient 0xFFFFFFFF, remainder 9.
- Flush: assert ex_flush at RUN cycle 10 of a DIVU -> ex_busy=0 next cycle, no ex_valid/ex_wreg pulse.
- Flush with ex_busy=0: id_valid=1 with ex_flush=1 -> bubble loaded.
